// File: rtl/mcp3201_pkg.sv
// rtl/mcp3201_pkg.sv - shared constants and types for the MCP3201 sample path
//
// Purpose: ADC result width and the averaging filter state encoding, shared by
//          the filter top and its ring buffer.
package mcp3201_pkg;

  localparam int ADC_W = 12;

  // FILL: fewer than DEPTH samples accepted since reset/clear.
  // RUN : window full; every accepted sample produces an average.
  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } filt_state_e;

endpackage

// File: rtl/sample_ring_buf.sv
// rtl/sample_ring_buf.sv - DEPTH x DATA_W sample store for the boxcar window
//
// Purpose: registered write, asynchronous read. The filter reads and writes the
//          same address each accept, so the read returns the oldest sample that
//          the write is about to replace.
// Ports:
//   clk    in  1            write clock
//   we     in  1            write enable
//   addr   in  LOG2_DEPTH   shared read/write address (filter write pointer)
//   wdata  in  DATA_W       sample to store
//   rdata  out DATA_W       current contents at addr
module sample_ring_buf
  import mcp3201_pkg::*;
#(
  parameter int DATA_W     = ADC_W,
  parameter int LOG2_DEPTH = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [LOG2_DEPTH-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  localparam int DEPTH = 1 << LOG2_DEPTH;

  // No reset: entries are only read once the window has been refilled.
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/mcp3201_avg_filter.sv
// rtl/mcp3201_avg_filter.sv - boxcar moving-average filter for MCP3201 samples
//
// Purpose: keeps the last 2**LOG2_DEPTH samples and their running sum, and emits
//          one truncated average per accepted sample once the window is full.
// Ports:
//   sys_clk         in  1                  system clock, rising edge
//   sys_rst_n       in  1                  asynchronous active-low reset
//   in_data         in  DATA_W             ADC sample
//   in_data_valid   in  1                  sample strobe
//   clear           in  1                  synchronous flush; wins over in_data_valid
//   out_data        out DATA_W             sum >> LOG2_DEPTH
//   out_data_valid  out 1                  1-cycle strobe qualifying out_data
//   out_sum         out DATA_W+LOG2_DEPTH  window sum at the last pulse
//   out_primed      out 1                  window full since reset/clear
module mcp3201_avg_filter
  import mcp3201_pkg::*;
#(
  parameter int DATA_W     = ADC_W,
  parameter int LOG2_DEPTH = 3
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst_n,
  input  logic [DATA_W-1:0]            in_data,
  input  logic                         in_data_valid,
  input  logic                         clear,
  output logic [DATA_W-1:0]            out_data,
  output logic                         out_data_valid,
  output logic [DATA_W+LOG2_DEPTH-1:0] out_sum,
  output logic                         out_primed
);

  localparam int DEPTH  = 1 << LOG2_DEPTH;
  localparam int SUM_W  = DATA_W + LOG2_DEPTH;
  localparam int FILL_W = LOG2_DEPTH + 1;

  filt_state_e           state_q, state_d;
  logic [LOG2_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [FILL_W-1:0]     fill_q, fill_d;
  logic [SUM_W-1:0]      sum_q, sum_d;
  logic [DATA_W-1:0]     out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic [SUM_W-1:0]      out_sum_q, out_sum_d;

  logic              accept;
  logic [DATA_W-1:0] rd_data;
  logic [SUM_W-1:0]  oldest;

  assign accept = in_data_valid & ~clear;

  sample_ring_buf #(
    .DATA_W     (DATA_W),
    .LOG2_DEPTH (LOG2_DEPTH)
  ) u_ring (
    .clk   (sys_clk),
    .we    (accept),
    .addr  (wr_ptr_q),
    .wdata (in_data),
    .rdata (rd_data)
  );

  // While filling, the slot at wr_ptr holds stale data from a previous window,
  // so nothing is evicted from the sum.
  assign oldest = (state_q == RUN) ? {{LOG2_DEPTH{1'b0}}, rd_data} : '0;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    fill_d      = fill_q;
    sum_d       = sum_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    out_sum_d   = out_sum_q;

    if (clear) begin
      state_d   = FILL;
      wr_ptr_d  = '0;
      fill_d    = '0;
      sum_d     = '0;
      out_sum_d = '0;
    end else if (in_data_valid) begin
      // Intermediate overflow of sum+in is harmless: the modular result is exact
      // because the true window sum always fits in SUM_W bits.
      sum_d    = sum_q + {{LOG2_DEPTH{1'b0}}, in_data} - oldest;
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (fill_q != FILL_W'(DEPTH)) begin
        fill_d = fill_q + 1'b1;
      end
      if (state_q == RUN || fill_q == FILL_W'(DEPTH - 1)) begin
        state_d     = RUN;
        out_valid_d = 1'b1;
        out_sum_d   = sum_d;
        out_data_d  = sum_d[SUM_W-1:LOG2_DEPTH];
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= FILL;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      sum_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      sum_q       <= sum_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
    end
  end

  assign out_data       = out_data_q;
  assign out_data_valid = out_valid_q;
  assign out_sum        = out_sum_q;
  assign out_primed     = (state_q == RUN);

endmodule

// File: tb/tb_mcp3201_avg_filter.sv
// tb/tb_mcp3201_avg_filter.sv - self-checking bench for mcp3201_avg_filter
module tb_mcp3201_avg_filter;

  localparam int DATA_W     = 12;
  localparam int LOG2_DEPTH = 3;
  localparam int DEPTH      = 8;

  logic                         sys_clk = 1'b0;
  logic                         sys_rst_n = 1'b0;
  logic [DATA_W-1:0]            in_data = '0;
  logic                         in_data_valid = 1'b0;
  logic                         clear = 1'b0;
  logic [DATA_W-1:0]            out_data;
  logic                         out_data_valid;
  logic [DATA_W+LOG2_DEPTH-1:0] out_sum;
  logic                         out_primed;

  mcp3201_avg_filter #(
    .DATA_W     (DATA_W),
    .LOG2_DEPTH (LOG2_DEPTH)
  ) dut (
    .sys_clk        (sys_clk),
    .sys_rst_n      (sys_rst_n),
    .in_data        (in_data),
    .in_data_valid  (in_data_valid),
    .clear          (clear),
    .out_data       (out_data),
    .out_data_valid (out_data_valid),
    .out_sum        (out_sum),
    .out_primed     (out_primed)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the window as a plain list of the most recent samples.
  int   win[$];
  int   exp_sum    = 0;
  int   exp_data   = 0;
  logic exp_valid  = 1'b0;
  logic exp_primed = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input bit keep_data);
    win.delete();
    exp_valid  = 1'b0;
    exp_sum    = 0;
    exp_primed = 1'b0;
    if (!keep_data) exp_data = 0;
  endtask

  task automatic model_step(input bit v, input int d, input bit c);
    int s;
    if (c) begin
      model_reset(1'b1);
    end else begin
      exp_valid = 1'b0;
      if (v) begin
        win.push_back(d);
        if (win.size() > DEPTH) void'(win.pop_front());
        if (win.size() == DEPTH) begin
          s = 0;
          foreach (win[i]) s += win[i];
          exp_sum    = s;
          exp_data   = s / DEPTH;
          exp_valid  = 1'b1;
          exp_primed = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"},  {31'd0, out_data_valid}, {31'd0, exp_valid});
    check({tag, ".primed"}, {31'd0, out_primed},     {31'd0, exp_primed});
    check({tag, ".sum"},    32'(out_sum),            32'(exp_sum));
    check({tag, ".data"},   32'(out_data),           32'(exp_data));
  endtask

  // One clock of stimulus, checked 1 time unit after the edge that consumes it.
  task automatic step(input bit v, input int d, input bit c, input string tag);
    in_data_valid = v;
    in_data       = DATA_W'(d);
    clear         = c;
    @(posedge sys_clk);
    #1;
    in_data_valid = 1'b0;
    clear         = 1'b0;
    model_step(v, d, c);
    check_all(tag);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge sys_clk);
    #1;
    check_all("reset");
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // 1: seven samples give no output, the eighth primes the window
    repeat (7) step(1'b1, 100, 1'b0, "t1_fill");
    step(1'b1, 100, 1'b0, "t1_prime");
    check("t1_sum_const",  32'(out_sum),  32'd800);
    check("t1_data_const", 32'(out_data), 32'd100);

    // 2: one large sample shifts the average, single-cycle pulse
    step(1'b1, 900, 1'b0, "t2_in");
    check("t2_sum_const",  32'(out_sum),  32'd1600);
    check("t2_data_const", 32'(out_data), 32'd200);
    step(1'b0, 0, 1'b0, "t2_idle");

    // 3: full-scale samples every cycle across a pointer wrap
    step(1'b0, 0, 1'b1, "t3_clear");
    repeat (16) step(1'b1, 4095, 1'b0, "t3_max");
    check("t3_sum_const",  32'(out_sum),  32'd32760);
    check("t3_data_const", 32'(out_data), 32'd4095);

    // 4: clear wins over a simultaneous valid
    step(1'b0, 0, 1'b1, "t4_clear0");
    repeat (5) step(1'b1, 10, 1'b0, "t4_fill");
    step(1'b1, 50, 1'b1, "t4_clear");
    check("t4_primed_const", {31'd0, out_primed}, 32'd0);
    check("t4_sum_const",    32'(out_sum),        32'd0);
    repeat (8) step(1'b1, 3, 1'b0, "t4_refill");
    check("t4_sum3_const",  32'(out_sum),  32'd24);
    check("t4_data3_const", 32'(out_data), 32'd3);

    // 5: asynchronous reset in the middle of a cycle
    step(1'b1, 3, 1'b0, "t5_run");
    #2;
    sys_rst_n = 1'b0;
    #1;
    model_reset(1'b0);
    check_all("t5_async");
    @(posedge sys_clk);
    #1;
    check_all("t5_held");
    #3;
    sys_rst_n = 1'b1;
    repeat (8) step(1'b1, 7, 1'b0, "t5_refill");
    check("t5_data_const", 32'(out_data), 32'd7);

    // 6: eviction of the oldest sample and truncating average
    step(1'b0, 0, 1'b1, "t6_clear");
    for (int i = 1; i <= 8; i++) step(1'b1, i, 1'b0, "t6_fill");
    check("t6_sum36_const", 32'(out_sum), 32'd36);
    step(1'b1, 9, 1'b0, "t6_evict");
    check("t6_sum44_const",  32'(out_sum),  32'd44);
    check("t6_data5_const",  32'(out_data), 32'd5);

    // Random stream against the model
    for (int n = 0; n < 400; n++) begin
      bit v, c;
      int d;
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 39) == 0);
      d = ($urandom_range(0, 7) == 0) ? 4095 : int'($urandom_range(0, 4095));
      step(v, d, c, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
